// File: rtl/net_resolver_reg.sv
// Clocked multi-driver net resolver: wire/wor/wand/supply0/supply1 per run-time mode,
// with registered result, saturating contention counter and sticky illegal-mode flag.
module net_resolver_reg #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N_DRV = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [2:0]             mode,
  input  logic [N_DRV-1:0]       drv_en,
  input  logic [N_DRV*WIDTH-1:0] drv_data,
  input  logic                   clr_cnt,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       res_data,
  output logic [WIDTH-1:0]       res_z,
  output logic [WIDTH-1:0]       conflict,
  output logic [CNT_W-1:0]       conflict_cnt,
  output logic                   mode_err
);

  localparam logic [2:0] MODE_WIRE = 3'd0;
  localparam logic [2:0] MODE_WOR  = 3'd1;
  localparam logic [2:0] MODE_WAND = 3'd2;
  localparam logic [2:0] MODE_SUP0 = 3'd3;
  localparam logic [2:0] MODE_SUP1 = 3'd4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] ones_c;
  logic [WIDTH-1:0] zeros_c;
  logic [WIDTH-1:0] data_c;
  logic [WIDTH-1:0] z_c;
  logic [WIDTH-1:0] conf_c;
  logic             reserved_c;

  // Per bit: does any enabled driver push a 1, and does any push a 0.
  always_comb begin
    ones_c  = '0;
    zeros_c = '0;
    for (int i = 0; i < int'(N_DRV); i++) begin
      if (drv_en[i]) begin
        ones_c  = ones_c  |  drv_data[i*WIDTH +: WIDTH];
        zeros_c = zeros_c | ~drv_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Mode-dependent resolution; reserved modes fall back to wire/tri.
  always_comb begin
    data_c     = '0;
    z_c        = ~(ones_c | zeros_c);
    conf_c     = '0;
    reserved_c = (mode > MODE_SUP1);
    case (mode)
      MODE_WOR: begin
        data_c = ones_c;
      end
      MODE_WAND: begin
        data_c = ones_c & ~zeros_c;
      end
      MODE_SUP0: begin
        data_c = '0;
        z_c    = '0;
      end
      MODE_SUP1: begin
        data_c = '1;
        z_c    = '0;
      end
      default: begin
        conf_c = ones_c & zeros_c;
        data_c = ones_c & ~zeros_c;
      end
    endcase
  end

  // Result registers and valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res_data  <= '0;
      res_z     <= '0;
      conflict  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        res_data <= data_c;
        res_z    <= z_c;
        conflict <= conf_c;
      end
    end
  end

  // Contention counter and sticky mode error; clear wins over update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
      mode_err     <= 1'b0;
    end else if (clr_cnt) begin
      conflict_cnt <= '0;
      mode_err     <= 1'b0;
    end else if (in_valid) begin
      if ((|conf_c) && (conflict_cnt != CNT_MAX))
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      if (reserved_c)
        mode_err <= 1'b1;
    end
  end

endmodule
